serial_subtract_ctrl: RTL
=========================

// Module: serial_subtract_ctrl
// PURPOSE
//   Bit-serial N-bit subtractor controller: sequences one internal full_subtract
//   cell (diff, borrowOut, a, b, borrowIn) LSB-first, one bit per clock.
//   Keeps the borrow in a flip-flop between cycles.
//   Exposes a start/busy/done handshake to the lab datapath top level.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range is 2..32
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   start       in   1      request; sampled only in IDLE
//   a_in        in   WIDTH  minuend; captured on the accepted start
//   b_in        in   WIDTH  subtrahend; captured on the accepted start
//   borrow_in   in   1      initial borrow; captured on the accepted start
//   busy        out  1      high in SHIFT and DONE states
//   done        out  1      one-cycle pulse; result valid from this cycle
//   diff_out    out  WIDTH  a_in - b_in - borrow_in (mod 2^WIDTH)
//   borrow_out  out  1      final borrow (1 = unsigned underflow)
// BEHAVIOUR
//   Reset (async): state=IDLE. busy, done, diff_out, borrow_out = 0.
//     All internal shift registers, counter and borrow FF are also cleared.
//   FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: on the edge where start=1:
//     - load a_sh=a_in, b_sh=b_in, brw=borrow_in, cnt=0; go to SHIFT.
//     - start=0: stay in IDLE.
//   SHIFT: each edge:
//     - cell inputs are a_sh[0], b_sh[0], brw.
//     - r_sh <= {cell.diff, r_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1.
//     - brw <= cell.borrowOut; cnt <= cnt+1.
//     - on the edge with cnt==WIDTH-1: go to DONE.
//     - on that same edge, diff_out <= final r_sh value and borrow_out <= final borrow.
//   DONE: done=1 for exactly one cycle; next edge -> IDLE.
//   Latency: start accepted at edge 0 -> done high in the cycle after edge WIDTH.
//     Throughput is one operation per WIDTH+2 cycles.
//   start while busy (SHIFT or DONE): ignored; no queueing.
//     A new operation may only be accepted in IDLE.
//   diff_out/borrow_out hold the previous result during SHIFT.
//     They change only on the completion edge and hold until the next completion.
//   a_in, b_in, borrow_in may change freely after acceptance; no effect on the operation.
//   Reset mid-operation: abort immediately; all outputs 0; done never pulses.
//   cnt width is $clog2(WIDTH)+1; cnt never wraps within an operation.
// CONFIGURATION
//   Macro SERSUB_FLAGS_EN:
//   - defined: adds outputs zero_flag (1 bit) and ovf_flag (1 bit).
//     - both registered on the completion edge; both reset to 0.
//     - zero_flag = (result == 0).
//     - ovf_flag (signed overflow) = (a[W-1]!=b[W-1]) && (result[W-1]!=a[W-1]),
//       using the captured operands.
//   - undefined: these ports and their logic do not exist; all other behaviour is identical.
// TESTING (WIDTH=8)
//   1. a=0x05, b=0x03, bin=0, start 1 cycle
//      -> done pulses 9 cycles after the start edge; diff=0x02, bout=0.
//   2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
//      [FLAGS_EN] zero=0, ovf=0.
//   3. a=0x80, b=0x01, bin=1 -> diff=0x7E, bout=0.
//      [FLAGS_EN] ovf=1.
//      Also a=0x5A, b=0x5A, bin=0 -> diff=0x00, bout=0. [FLAGS_EN] zero=1.
//   4. Hold start=1 continuously with a=0x10, b=0x01
//      -> exactly one operation per 10 cycles; busy low only 1 cycle between runs.
//      Change a_in mid-run -> no effect on the 0x0F result.
//   5. Assert rst during cycle 4 of SHIFT, between clock edges
//      -> outputs 0 immediately; no done pulse.
//      Next start with a=0x09, b=0x04 -> diff=0x05.
//   6. Exhaustive check: all 65536 a/b pairs with bin=0 and bin=1
//      -> {bout, diff} == ({1'b0, a} - b - bin) mod 2^9.

Source files
------------

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_subtract cell, LSB first, one bit per clock.
// Optional zero/signed-overflow flag outputs when SERSUB_FLAGS_EN is defined.

module full_subtract (
  input  logic a,
  input  logic b,
  input  logic borrowIn,
  output logic diff,
  output logic borrowOut
);
  assign diff      = a ^ b ^ borrowIn;
  assign borrowOut = (~a & b) | (~(a ^ b) & borrowIn);
endmodule

module serial_subtract_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
`ifdef SERSUB_FLAGS_EN
  output logic             zero_flag,
  output logic             ovf_flag,
`endif
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [WIDTH-2:0] r_sh_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q;
  logic             busy_q, done_q, bout_q;
  logic [WIDTH-1:0] diff_q;

  logic             cell_diff, cell_bout;
  logic [WIDTH-1:0] r_full_d;
  logic [WIDTH-2:0] r_sh_d;
  logic [CW-1:0]    cnt_d;
  logic             last_d;

  full_subtract u_cell (
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .borrowIn (brw_q),
    .diff     (cell_diff),
    .borrowOut(cell_bout)
  );

  // The oldest result bit is always shifted out, so WIDTH-1 stored bits plus
  // the live cell output form the complete result on the final step.
  always_comb begin
    r_full_d = {cell_diff, r_sh_q};
    r_sh_d   = r_full_d[WIDTH-1:1];
    cnt_d    = cnt_q + 1'b1;
    last_d   = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef SERSUB_FLAGS_EN
  logic zero_q, ovf_q;
  assign zero_flag = zero_q;
  assign ovf_flag  = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERSUB_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a_in;
            b_sh_q  <= b_in;
            brw_q   <= borrow_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          r_sh_q <= r_sh_d;
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          brw_q  <= cell_bout;
          cnt_q  <= cnt_d;
          if (last_d) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            diff_q  <= r_full_d;
            bout_q  <= cell_bout;
`ifdef SERSUB_FLAGS_EN
            // On the last step bit 0 of each operand shifter holds its original MSB.
            zero_q  <= (r_full_d == '0);
            ovf_q   <= (a_sh_q[0] != b_sh_q[0]) && (r_full_d[WIDTH-1] != a_sh_q[0]);
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff_out   = diff_q;
  assign borrow_out = bout_q;

endmodule
